codificador_display: RTL and testbench

//  Producer side of the 4-bit symbol-code bus consumed by the 7-segment decoder.

---
 rtl/codificador_display_pkg.sv | 15 +
 rtl/codificador_display_scan_prescaler.sv | 32 +++
 rtl/codificador_display.sv | 79 +++++++
 tb/tb_codificador_display.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/codificador_display_pkg.sv
// codificador_display_pkg: symbol codes shared with the segment decoder, plus display state encoding
package codificador_display_pkg;
  localparam logic [3:0] C_0     = 4'd0;
  localparam logic [3:0] C_1     = 4'd1;
  localparam logic [3:0] C_2     = 4'd2;
  localparam logic [3:0] C_3     = 4'd3;
  localparam logic [3:0] C_4     = 4'd4;
  localparam logic [3:0] C_5     = 4'd5;
  localparam logic [3:0] C_E     = 4'd6;
  localparam logic [3:0] C_N     = 4'd7;
  localparam logic [3:0] C_P     = 4'd8;
  localparam logic [3:0] C_DOT   = 4'd9;
  localparam logic [3:0] C_BLANK = 4'd15;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_VEND = 2'd1, S_ERR = 2'd2} state_t;
endpackage

// File: rtl/codificador_display_scan_prescaler.sv
// codificador_display_scan_prescaler: divides clk into digit slots and reports the digit index and frame end
module codificador_display_scan_prescaler #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] idx,
  output logic       frame_end
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick;
  // next prescaler count and digit index; a frame ends when the last digit's slot expires
  always_comb begin
    tick      = div_q == DW'(SCAN_DIV - 1);
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    frame_end = tick && idx_q == 2'd3;
  end
  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end
  assign idx = idx_q;
endmodule

// File: rtl/codificador_display.sv
// codificador_display: scans the 4-digit display showing credit or a timed vend/error message
module codificador_display
  import codificador_display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int MSG_TICKS = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          credit,
  input  logic                evt_vend,
  input  logic                evt_error,
  output logic [3:0]          code,
  output logic [N_DIGITS-1:0] digit_en,
  output logic                busy
);
  localparam int TW = $clog2(MSG_TICKS + 1);
  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [3:0]          code_q, code_d;
  logic [N_DIGITS-1:0] en_q, en_d;
  logic [1:0]          idx;
  logic                frame_end;
  logic [3:0]          credit_code, idle_code, vend_code, err_code;

  codificador_display_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .frame_end(frame_end)
  );

  // events override the timer; the timer counts frame ends and releases after MSG_TICKS+1 of them,
  // because the first counted frame is the partial one the message started in
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (evt_error) begin
      state_d = S_ERR;
      timer_d = '0;
    end else if (evt_vend && state_q != S_ERR) begin
      state_d = S_VEND;
      timer_d = '0;
    end else if (state_q != S_IDLE && frame_end) begin
      state_d = timer_q == TW'(MSG_TICKS) ? S_IDLE : state_q;
      timer_d = timer_q == TW'(MSG_TICKS) ? '0 : timer_q + 1'b1;
    end
  end

  // symbol lookup for the digit currently being scanned
  always_comb begin
    credit_code = credit > 3'd5 ? C_E : {1'b0, credit};
    idle_code   = idx == 2'd0 ? credit_code : C_BLANK;
    vend_code   = idx == 2'd0 ? C_DOT : idx == 2'd1 ? C_N : idx == 2'd2 ? C_E : C_P;
    err_code    = idx == 2'd0 ? C_E : idx == 2'd1 ? C_BLANK : idx == 2'd2 ? C_N : C_E;
    code_d      = state_q == S_VEND ? vend_code : state_q == S_ERR ? err_code : idle_code;
    en_d        = N_DIGITS'(1) << idx;
  end

  // state, timer and the paired code/enable output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      code_q  <= C_BLANK;
      en_q    <= N_DIGITS'(1);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  assign code     = code_q;
  assign digit_en = en_q;
  assign busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_codificador_display.sv
// tb_codificador_display: random and directed stimulus checked against a cycle-count based display model
module tb_codificador_display;
  localparam int SD = 4;
  localparam int MT = 2;
  localparam int F  = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] credit = 3'd3;
  logic       evt_vend = 1'b0;
  logic       evt_error = 1'b0;
  logic [3:0] code;
  logic [3:0] digit_en;
  logic       busy;
  int checks = 0;
  int errors = 0;

  codificador_display #(.N_DIGITS(4), .SCAN_DIV(SD), .MSG_TICKS(MT)) dut (
    .clk      (clk),
    .rst      (rst),
    .credit   (credit),
    .evt_vend (evt_vend),
    .evt_error(evt_error),
    .code     (code),
    .digit_en (digit_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // message tables indexed by digit number (0 = rightmost)
  function automatic logic [3:0] exp_code(input int st, input int d, input int cr);
    logic [3:0] vt[4];
    logic [3:0] et[4];
    vt = '{4'd9, 4'd7, 4'd6, 4'd8};
    et = '{4'd6, 4'd15, 4'd7, 4'd6};
    if (st == 1) return vt[d];
    if (st == 2) return et[d];
    return d != 0 ? 4'd15 : (cr > 5 ? 4'd6 : 4'(cr));
  endfunction

  // a message entered at cycle c0 ends at the (MT+1)th frame-end cycle after c0
  function automatic int msg_end(input int c0);
    int c1;
    c1 = c0 + 1 + (F - 1 - (c0 + 1) % F);
    return c1 + MT * F;
  endfunction

  int         cyc;
  int         m_state;
  int         end_cyc;
  logic [3:0] e_code;
  logic [3:0] e_en;
  logic       e_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_state = 0; end_cyc = 0;
      e_code = 4'd15; e_en = 4'b0001; e_busy = 1'b0;
    end else begin
      e_code = exp_code(m_state, (cyc / SD) % 4, int'(credit));
      e_en   = 4'(1 << ((cyc / SD) % 4));
      if (evt_error) begin
        m_state = 2; end_cyc = msg_end(cyc);
      end else if (evt_vend && m_state != 2) begin
        m_state = 1; end_cyc = msg_end(cyc);
      end else if (m_state != 0 && cyc == end_cyc) m_state = 0;
      e_busy = m_state != 0;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("code", 32'(code), 32'(e_code));
      chk("digit_en", 32'(digit_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic capture(output logic [15:0] c);
    c = 16'hAAAA;
    for (int i = 0; i < F; i++) begin
      step();
      for (int d = 0; d < 4; d++) if (digit_en == 4'(1 << d)) c[d*4 +: 4] = code;
    end
  endtask

  task automatic hold_len(input int start, output int n);
    n = start;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  logic [15:0] cap;
  int          n;

  initial begin
    #12;
    chk("rst_code", 32'(code), 32'd15);
    chk("rst_en", 32'(digit_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("t1_en0", 32'(digit_en), 32'b0001); chk("t1_c0", 32'(code), 32'd3);
    repeat (4) step();
    chk("t1_en1", 32'(digit_en), 32'b0010); chk("t1_c1", 32'(code), 32'd15);
    repeat (4) step();
    chk("t1_en2", 32'(digit_en), 32'b0100); chk("t1_c2", 32'(code), 32'd15);
    repeat (4) step();
    chk("t1_en3", 32'(digit_en), 32'b1000); chk("t1_c3", 32'(code), 32'd15);
    step();
    evt_vend = 1'b1; step(); evt_vend = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    capture(cap);
    chk("t2_vend_codes", 32'(cap), 32'h8679);
    hold_len(F, n);
    chk("t2_hold_in_32_48", 32'(n >= 32 && n <= 48), 32'd1);
    chk("t2_idle", 32'(busy), 32'd0);
    evt_vend = 1'b1; evt_error = 1'b1; step(); evt_vend = 1'b0; evt_error = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    capture(cap);
    chk("t3_err_codes", 32'(cap), 32'h67F6);
    evt_vend = 1'b1; step(); evt_vend = 1'b0;
    hold_len(F + 1, n);
    chk("t3_hold_in_32_48", 32'(n >= 32 && n <= 48), 32'd1);
    evt_vend = 1'b1; step(); evt_vend = 1'b0;
    repeat (5) step();
    evt_error = 1'b1; step(); evt_error = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    capture(cap);
    chk("t4_err_codes", 32'(cap), 32'h67F6);
    hold_len(F, n);
    chk("t4_hold_in_32_48", 32'(n >= 32 && n <= 48), 32'd1);
    credit = 3'd7;
    step();
    capture(cap);
    chk("t5_credit7_digit0", 32'(cap[3:0]), 32'd6);
    credit = 3'd2;
    n = 0;
    while (digit_en == 4'b0001 && n < 40) begin step(); n++; end
    while (digit_en != 4'b0001 && n < 40) begin step(); n++; end
    chk("t5_digit0_found", 32'(n < 40), 32'd1);
    chk("t5_credit2", 32'(code), 32'd2);
    credit = 3'd4;
    step();
    chk("t5_credit4", 32'(code), 32'd4);
    evt_vend = 1'b1; step(); evt_vend = 1'b0;
    repeat (10) step();
    #1 rst = 1'b1;
    #1;
    chk("t6_code", 32'(code), 32'd15);
    chk("t6_en", 32'(digit_en), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    chk("t6_resume_en", 32'(digit_en), 32'b0001);
    chk("t6_resume_code", 32'(code), 32'd4);
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) credit = 3'($urandom_range(0, 7));
      evt_vend  = $urandom_range(0, 39) == 0;
      evt_error = $urandom_range(0, 59) == 0;
      step();
    end
    evt_vend = 1'b0; evt_error = 1'b0;
    repeat (60) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
